// File: rtl/ram_port_scheduler_pkg.sv
// Shared constants and types for the RAM port scheduler.
package ram_port_scheduler_pkg;

    // Number of physical RAM ports (A..D).
    localparam int unsigned NumPorts = 4;

    // Requester count is limited to 5..8, so a 3-bit index always suffices.
    localparam int unsigned ReqIdxW = 3;

    typedef logic [1:0]         port_idx_t;
    typedef logic [ReqIdxW-1:0] req_idx_t;

    // Address width for a RAM of the given depth (at least one bit).
    function automatic int unsigned calc_aw(input int unsigned height);
        return (height > 1) ? $clog2(height) : 1;
    endfunction

endpackage

// File: rtl/ram_port_scheduler_rr_grant_scan.sv
// Combinational circular scan: grants up to NumPorts requesters starting at
// rr_ptr, skipping writes that collide with an earlier granted write.
module rr_grant_scan
    import ram_port_scheduler_pkg::*;
#(
    parameter int unsigned NREQ = 6,
    parameter int unsigned AW   = 6
) (
    input  logic                          rst_i,
    input  logic [NREQ-1:0]               req_i,
    input  logic [NREQ-1:0]               req_we_i,
    input  logic [NREQ*AW-1:0]            req_addr_i,
    input  req_idx_t                      rr_ptr_i,
    output logic [NREQ-1:0]               gnt_o,
    output logic [NumPorts-1:0]           port_vld_o,
    output req_idx_t [NumPorts-1:0]       port_req_o,
    output logic                          any_gnt_o,
    output req_idx_t                      last_gnt_o
);

    logic [ReqIdxW:0] pos;
    logic [2:0]       cnt;
    req_idx_t         idx;
    logic             conflict;

    // Walk requesters in circular order, assigning ports in grant order.
    always_comb begin
        gnt_o      = '0;
        port_vld_o = '0;
        port_req_o = '0;
        any_gnt_o  = 1'b0;
        last_gnt_o = '0;
        pos        = '0;
        cnt        = '0;
        idx        = '0;
        conflict   = 1'b0;
        if (!rst_i) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                pos = {1'b0, rr_ptr_i} + (ReqIdxW+1)'(j);
                if (pos >= (ReqIdxW+1)'(NREQ)) begin
                    pos = pos - (ReqIdxW+1)'(NREQ);
                end
                idx      = pos[ReqIdxW-1:0];
                conflict = 1'b0;
                // Only write-after-write to the same address in one cycle is blocked.
                if (req_we_i[idx]) begin
                    for (int unsigned k = 0; k < NumPorts; k++) begin
                        if ((3'(k) < cnt) && req_we_i[port_req_o[k]] &&
                            (req_addr_i[port_req_o[k]*AW +: AW] == req_addr_i[idx*AW +: AW])) begin
                            conflict = 1'b1;
                        end
                    end
                end
                if (req_i[idx] && (cnt < 3'(NumPorts)) && !conflict) begin
                    gnt_o[idx]              = 1'b1;
                    port_vld_o[cnt[1:0]]    = 1'b1;
                    port_req_o[cnt[1:0]]    = idx;
                    any_gnt_o               = 1'b1;
                    last_gnt_o              = idx;
                    cnt                     = cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/ram_port_scheduler.sv
// Schedules up to NREQ requesters onto a 4-port RAM each cycle with
// round-robin fairness, registered read return and address-range checking.
module ram_port_scheduler
    import ram_port_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned HEIGHT = 48,
    parameter int unsigned NREQ   = 6,
    localparam int unsigned AW    = calc_aw(HEIGHT)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NREQ-1:0]            req_i,
    input  logic [NREQ-1:0]            req_we_i,
    input  logic [NREQ*AW-1:0]         req_addr_i,
    input  logic [NREQ*WIDTH-1:0]      req_wdata_i,
    output logic [NREQ-1:0]            gnt_o,
    output logic [NREQ-1:0]            rvalid_o,
    output logic [NREQ*WIDTH-1:0]      rdata_o,
    output logic                       addr_err_o,
    output logic [NumPorts*AW-1:0]     ram_addr_o,
    output logic [NumPorts-1:0]        ram_we_o,
    output logic [NumPorts*WIDTH-1:0]  ram_wdata_o,
    input  logic [NumPorts*WIDTH-1:0]  ram_q_i
);

    localparam logic [AW:0] HeightW = (AW+1)'(HEIGHT);

    req_idx_t                rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]         rvalid_q, rvalid_d;
    logic [NREQ*WIDTH-1:0]   rdata_q, rdata_d;
    logic                    addr_err_q, addr_err_d;

    logic [NumPorts-1:0]     port_vld;
    req_idx_t [NumPorts-1:0] port_req;
    logic [NumPorts-1:0]     port_oob;
    logic                    any_gnt;
    req_idx_t                last_gnt;
    req_idx_t                r;
    logic [AW-1:0]           a;

    rr_grant_scan #(
        .NREQ (NREQ),
        .AW   (AW)
    ) u_scan (
        .rst_i      (rst_i),
        .req_i      (req_i),
        .req_we_i   (req_we_i),
        .req_addr_i (req_addr_i),
        .rr_ptr_i   (rr_ptr_q),
        .gnt_o      (gnt_o),
        .port_vld_o (port_vld),
        .port_req_o (port_req),
        .any_gnt_o  (any_gnt),
        .last_gnt_o (last_gnt)
    );

    // Port mux: route each granted requester onto its RAM port.
    always_comb begin
        ram_addr_o  = '0;
        ram_we_o    = '0;
        ram_wdata_o = '0;
        port_oob    = '0;
        r           = '0;
        a           = '0;
        for (int unsigned k = 0; k < NumPorts; k++) begin
            if (port_vld[k]) begin
                r                           = port_req[k];
                a                           = req_addr_i[r*AW +: AW];
                port_oob[k]                 = ({1'b0, a} >= HeightW);
                ram_addr_o[k*AW +: AW]      = a;
                // Out-of-range writes are granted but suppressed at the RAM.
                ram_we_o[k]                 = req_we_i[r] & ~port_oob[k];
                if (req_we_i[r]) begin
                    ram_wdata_o[k*WIDTH +: WIDTH] = req_wdata_i[r*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Next-state: capture read data, flag range errors, advance the pointer.
    always_comb begin
        rvalid_d   = '0;
        rdata_d    = rdata_q;
        addr_err_d = 1'b0;
        for (int unsigned k = 0; k < NumPorts; k++) begin
            if (port_vld[k]) begin
                if (port_oob[k]) begin
                    addr_err_d = 1'b1;
                end
                if (!req_we_i[port_req[k]]) begin
                    rvalid_d[port_req[k]] = 1'b1;
                    rdata_d[port_req[k]*WIDTH +: WIDTH] =
                        port_oob[k] ? '0 : ram_q_i[k*WIDTH +: WIDTH];
                end
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (any_gnt) begin
            rr_ptr_d = (32'(last_gnt) == NREQ - 1) ? '0 : last_gnt + req_idx_t'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            addr_err_q <= addr_err_d;
        end
    end

    // A read granted just before reset asserts must not be reported.
    always_comb begin
        rvalid_o   = rst_i ? '0 : rvalid_q;
        rdata_o    = rdata_q;
        addr_err_o = addr_err_q;
    end

endmodule

// File: tb/tb_ram_port_scheduler.sv
// Scoreboard bench: stimulus pushes expected read returns and range errors,
// a negedge monitor pops and compares them when the DUT presents them.
module tb_ram_port_scheduler;

    localparam int W  = 32;
    localparam int H  = 48;
    localparam int N  = 6;
    localparam int AW = 6;
    localparam int P  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req, req_we;
    logic [N*AW-1:0]  req_addr;
    logic [N*W-1:0]   req_wdata;
    logic [N-1:0]     gnt, rvalid;
    logic [N*W-1:0]   rdata;
    logic             addr_err;
    logic [P*AW-1:0]  ram_addr;
    logic [P-1:0]     ram_we;
    logic [P*W-1:0]   ram_wdata;
    logic [P*W-1:0]   ram_q;

    logic [W-1:0]     mem [H];

    typedef struct {
        int           idx;
        logic [W-1:0] data;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      err_pending = 0;
    int      n_checks = 0;
    int      n_pass = 0;

    always #5 clk = ~clk;

    ram_port_scheduler #(
        .WIDTH  (W),
        .HEIGHT (H),
        .NREQ   (N)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .addr_err_o  (addr_err),
        .ram_addr_o  (ram_addr),
        .ram_we_o    (ram_we),
        .ram_wdata_o (ram_wdata),
        .ram_q_i     (ram_q)
    );

    // 4-port RAM model: asynchronous read, write on rising edge.
    always_comb begin
        for (int k = 0; k < P; k++) begin
            if (int'(ram_addr[k*AW +: AW]) < H) begin
                ram_q[k*W +: W] = mem[ram_addr[k*AW +: AW]];
            end else begin
                ram_q[k*W +: W] = 32'hBAD0BAD0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < H; a++) mem[a] <= 32'h1000 + a;
        end
        for (int k = 0; k < P; k++) begin
            if (ram_we[k] && int'(ram_addr[k*AW +: AW]) < H) begin
                mem[ram_addr[k*AW +: AW]] <= ram_wdata[k*W +: W];
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compare every presented read return and error pulse.
    always @(negedge clk) begin
        rd_exp_t e;
        for (int i = 0; i < N; i++) begin
            if (rvalid[i]) begin
                if (rd_q.size() == 0) begin
                    check("rvalid_unexpected", 128'(rvalid), 128'(0));
                end else begin
                    e = rd_q.pop_front();
                    check("rvalid_idx", 128'(i), 128'(e.idx));
                    check("rdata", 128'(rdata[i*W +: W]), 128'(e.data));
                end
            end
        end
        if (addr_err) begin
            check("addr_err_expected", 128'(err_pending != 0), 128'(1));
            if (err_pending > 0) err_pending--;
        end
    end

    task automatic clr();
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic set_rq(input int i, input logic we, input int a, input logic [W-1:0] d);
        req[i] = 1'b1;
        req_we[i] = we;
        req_addr[i*AW +: AW] = AW'(a);
        req_wdata[i*W +: W] = d;
    endtask

    task automatic push_rd(input int i, input logic [W-1:0] d);
        rd_exp_t e;
        e.idx = i;
        e.data = d;
        rd_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with pending writes: nothing may reach the RAM.
        rst = 1'b1;
        clr();
        for (int i = 0; i < N; i++) set_rq(i, 1'b1, i, 32'hDEAD);
        @(negedge clk);
        check("rst_gnt", 128'(gnt), 128'(0));
        check("rst_ram_we", 128'(ram_we), 128'(0));
        check("rst_ram_addr", 128'(ram_addr), 128'(0));
        check("rst_ram_wdata", 128'(ram_wdata), 128'(0));
        tick();
        tick();
        rst = 1'b0;
        clr();
        @(negedge clk);
        check("post_rst_rvalid", 128'(rvalid), 128'(0));
        check("post_rst_rdata", 128'(rdata), 128'(0));
        check("post_rst_addr_err", 128'(addr_err), 128'(0));
        tick();

        // Four reads at addresses 0..3.
        for (int i = 0; i < 4; i++) set_rq(i, 1'b0, i, 0);
        @(negedge clk);
        check("r037_gnt", 128'(gnt), 128'(6'b001111));
        check("r037_addr", 128'(ram_addr), 128'({6'd3, 6'd2, 6'd1, 6'd0}));
        check("r037_we", 128'(ram_we), 128'(0));
        for (int i = 0; i < 4; i++) push_rd(i, 32'h1000 + i);
        tick();

        // rr_ptr must now be 4; these reads are then cut off by reset.
        clr();
        for (int i = 0; i < N; i++) set_rq(i, 1'b0, 20 + i, 0);
        @(negedge clk);
        check("r037_rvalid", 128'(rvalid), 128'(6'b001111));
        check("r037_ptr_gnt", 128'(gnt), 128'(6'b110011));
        check("r037_ptr_addr", 128'(ram_addr), 128'({6'd21, 6'd20, 6'd25, 6'd24}));
        tick();
        rst = 1'b1;
        clr();
        @(negedge clk);
        check("r041_rvalid_in_rst", 128'(rvalid), 128'(0));
        check("r041_gnt_in_rst", 128'(gnt), 128'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("r041_rvalid_after", 128'(rvalid), 128'(0));
        check("r041_rdata_cleared", 128'(rdata), 128'(0));
        tick();

        // Six readers, three cycles of rotation from rr_ptr=0.
        for (int i = 0; i < N; i++) set_rq(i, 1'b0, 10 + i, 0);
        @(negedge clk);
        check("r038_c1_gnt", 128'(gnt), 128'(6'b001111));
        check("r038_c1_addr", 128'(ram_addr), 128'({6'd13, 6'd12, 6'd11, 6'd10}));
        for (int i = 0; i < 4; i++) push_rd(i, 32'h1000 + 10 + i);
        tick();
        @(negedge clk);
        check("r038_c2_gnt", 128'(gnt), 128'(6'b110011));
        check("r038_c2_addr", 128'(ram_addr), 128'({6'd11, 6'd10, 6'd15, 6'd14}));
        push_rd(0, 32'h100A); push_rd(1, 32'h100B); push_rd(4, 32'h100E); push_rd(5, 32'h100F);
        tick();
        @(negedge clk);
        check("r038_c3_gnt", 128'(gnt), 128'(6'b111100));
        check("r038_c3_addr", 128'(ram_addr), 128'({6'd15, 6'd14, 6'd13, 6'd12}));
        for (int i = 2; i < 6; i++) push_rd(i, 32'h1000 + 10 + i);
        tick();
        clr();
        @(negedge clk);
        check("idle_gnt", 128'(gnt), 128'(0));
        tick();

        // Two writers to address 7: second must wait a cycle.
        set_rq(0, 1'b1, 7, 32'hA);
        set_rq(1, 1'b1, 7, 32'hB);
        @(negedge clk);
        check("r039_c1_gnt", 128'(gnt), 128'(6'b000001));
        check("r039_c1_we", 128'(ram_we), 128'(4'b0001));
        check("r039_c1_addr", 128'(ram_addr), 128'(24'd7));
        check("r039_c1_wdata", 128'(ram_wdata), 128'(32'hA));
        tick();
        clr();
        set_rq(1, 1'b1, 7, 32'hB);
        @(negedge clk);
        check("r039_c2_gnt", 128'(gnt), 128'(6'b000010));
        check("r039_c2_we", 128'(ram_we), 128'(4'b0001));
        check("r039_c2_wdata", 128'(ram_wdata), 128'(32'hB));
        tick();
        clr();
        set_rq(0, 1'b0, 7, 0);
        @(negedge clk);
        check("r039_rd_gnt", 128'(gnt), 128'(6'b000001));
        push_rd(0, 32'hB);
        tick();

        // Writes at the last legal address and one past it.
        clr();
        set_rq(2, 1'b1, 47, 32'h47);
        set_rq(3, 1'b1, 48, 32'h48);
        @(negedge clk);
        check("r040_gnt", 128'(gnt), 128'(6'b001100));
        check("r040_we", 128'(ram_we), 128'(4'b0001));
        check("r040_addr", 128'(ram_addr), 128'({6'd0, 6'd0, 6'd48, 6'd47}));
        err_pending++;
        tick();
        clr();
        set_rq(4, 1'b0, 47, 0);
        set_rq(5, 1'b0, 48, 0);
        @(negedge clk);
        check("r040_err_pulse", 128'(addr_err), 128'(1));
        check("r040_rd_gnt", 128'(gnt), 128'(6'b110000));
        push_rd(4, 32'h47);
        push_rd(5, 32'h0);
        err_pending++;
        tick();
        clr();
        @(negedge clk);
        check("r040_rd_err", 128'(addr_err), 128'(1));
        tick();
        @(negedge clk);
        check("r040_err_cleared", 128'(addr_err), 128'(0));
        tick();

        // Same-cycle read and write of address 9.
        set_rq(0, 1'b0, 9, 0);
        set_rq(5, 1'b1, 9, 32'h99);
        @(negedge clk);
        check("r042_gnt", 128'(gnt), 128'(6'b100001));
        check("r042_we", 128'(ram_we), 128'(4'b0010));
        check("r042_addr", 128'(ram_addr), 128'({6'd0, 6'd0, 6'd9, 6'd9}));
        push_rd(0, 32'h1009);
        tick();
        clr();
        set_rq(1, 1'b0, 9, 0);
        @(negedge clk);
        check("r042_rd2_gnt", 128'(gnt), 128'(6'b000010));
        push_rd(1, 32'h99);
        tick();
        clr();
        tick();
        @(negedge clk);
        check("r042_rdata0_held", 128'(rdata[0 +: W]), 128'(32'h1009));
        tick();
        tick();

        check("rd_queue_drained", 128'(rd_q.size()), 128'(0));
        check("err_queue_drained", 128'(err_pending), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_port_scheduler.md
RAM_PORT_SCHEDULER -- requirements
Module: ram_port_scheduler

Interface
REQ-001 Parameter WIDTH, default 32, data word width.
REQ-002 Parameter HEIGHT, default 48, RAM depth in words; AW = $clog2(HEIGHT).
REQ-003 Parameter NREQ, default 6, number of requesters; legal range 5..8.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester access request; held high until granted.
REQ-007 req_we  input  NREQ  per-requester access type: 1 = write, 0 = read.
REQ-008 req_addr  input  NREQ*AW  per-requester address, requester i at bits [i*AW +: AW].
REQ-009 req_wdata  input  NREQ*WIDTH  per-requester write data.
REQ-010 gnt  output  NREQ  combinational grant; the access is performed in this cycle.
REQ-011 rvalid  output  NREQ  registered read-data-valid, one cycle after a read grant.
REQ-012 rdata  output  NREQ*WIDTH  registered read data for requester i.
REQ-013 addr_err  output  1  registered pulse, one cycle after any granted access with address >= HEIGHT.
REQ-014 ram_addr  output  4*AW  addresses to RAM ports A..D, port k at bits [k*AW +: AW].
REQ-015 ram_we  output  4  write enables to RAM ports A..D.
REQ-016 ram_wdata  output  4*WIDTH  write data to RAM ports A..D.
REQ-017 ram_q  input  4*WIDTH  asynchronous read data from RAM ports A..D.

Function
REQ-018 Each cycle, scan requesters in circular order starting at rr_ptr and grant at most 4.
REQ-019 A requester is skipped in the current cycle if it is a write and a requester granted earlier in the same scan is writing the same address.
REQ-020 Reads are never skipped for address conflicts; a read of an address written in the same cycle returns the pre-write data.
REQ-021 The k-th grant in scan order (k = 0..3) drives RAM port k; unused ports drive we=0, addr=0, wdata=0.
REQ-022 A granted write with address >= HEIGHT drives ram_we=0 on its port, and addr_err is asserted in the next cycle.
REQ-023 A granted read samples ram_q of its port in the grant cycle; in the next cycle rvalid[i]=1 and rdata[i] holds that value, or 0 if the address is >= HEIGHT.
REQ-024 rvalid[i] is high for exactly one cycle per read grant; rdata[i] holds its value until the next read grant to requester i.
REQ-025 Granted writes never assert rvalid.
REQ-026 If at least one grant is issued, rr_ptr becomes (index of last granted requester + 1) mod NREQ; otherwise rr_ptr is unchanged.
REQ-027 A skipped requester, or one beyond the 4-grant limit, is granted within ceil(NREQ/4)+1 cycles as long as its req stays high.
REQ-028 gnt[i] is never asserted while req[i] is low.
REQ-029 Outputs gnt and ram_* depend combinationally on req*, rr_ptr and rst only.

Reset
REQ-030 While rst=1: gnt=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-031 On a clock edge with rst=1: rr_ptr=0, rvalid=0, rdata=0, addr_err=0.
REQ-032 Requests present in a reset cycle are not performed and are not remembered.
REQ-033 Reads granted in the cycle before reset asserts produce no rvalid.

Structure
REQ-034 Shared package holds the port count constant (4), AW derivation, and the port index type.
REQ-035 One sub-module, rr_grant_scan, holds the combinational circular scan with write-conflict masking; it outputs the grant vector and the per-port requester index.
REQ-036 The scheduler top holds rr_ptr, the per-requester rdata/rvalid registers, addr_err and the port mux.

Verification
REQ-037 After reset, req=6'b001111 with all reads at addresses 0..3 -> gnt=001111 and ports A..D carry addresses 0..3; next cycle rvalid=001111 with matching ram_q values, and rr_ptr=4.
REQ-038 All 6 requesters hold read requests -> cycle 1 grants 0..3, cycle 2 grants 4,5,0,1, cycle 3 grants 2,3,4,5.
REQ-039 Requesters 0 and 1 both write address 7 (data 0xA, 0xB) with rr_ptr=0 -> cycle 1 grants only 0 (ram_we=0001); cycle 2 grants 1; the RAM finally holds 0xB.
REQ-040 Requester 2 writes address 47 and requester 3 writes address 48 (HEIGHT=48) -> both are granted; the port for 48 has we=0; addr_err=1 in the next cycle only.
REQ-041 Read grant in cycle N, rst=1 in cycle N+1 -> rvalid stays 0, rr_ptr=0, and rdata is cleared.
REQ-042 Requester 5 writes address 9 while requester 0 reads address 9 in the same cycle -> both are granted; rdata[0] holds the old value, and a read of address 9 in the following cycle returns the new value.
